wr_en_decoder: RTL and testbench

Parametrised, registered N-to-2^N write-enable decoder for the register file. It turns an accepted write address into a one-cycle one-hot write strobe, with a configurable hardwired zero register that is never enabled. A built-in clear sequencer sweeps every register index once, so the file can be zeroed without datapath involvement. It sits between the writeback stage and the register-file write ports.

---
 rtl/wr_en_decoder_pkg.sv | 17 +
 rtl/wr_en_decoder_if.sv | 24 ++
 rtl/wr_en_decoder_dec_onehot.sv | 25 ++
 rtl/wr_en_decoder.sv | 91 +++++++++
 tb/tb_wr_en_decoder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/wr_en_decoder_pkg.sv
// Shared types and helpers for the register-file write-enable decoder.
package wr_en_decoder_pkg;

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    localparam int unsigned MaxAddrW = 10;
    localparam int unsigned MaxOutW  = 2**MaxAddrW;

    // Callers take the low 2**ADDR_W bits for their own address width.
    function automatic logic [MaxOutW-1:0] onehot(input logic [MaxAddrW-1:0] idx);
        logic [MaxOutW-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/wr_en_decoder_if.sv
// Write-request, clear-sweep and strobe bundle between writeback and the decoder.
interface wr_en_decoder_if #(
    parameter int unsigned ADDR_W = 5
) ();

    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr;
    logic                   clr_start;
    logic                   busy;
    logic                   clr_done;
    logic [2**ADDR_W-1:0]   we_out;

    modport master (
        output wr_valid, wr_addr, clr_start,
        input  wr_ready, busy, clr_done, we_out
    );

    modport slave (
        input  wr_valid, wr_addr, clr_start,
        output wr_ready, busy, clr_done, we_out
    );

endinterface

// File: rtl/wr_en_decoder_dec_onehot.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
module dec_onehot
    import wr_en_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]    in,
    input  logic                 e,
    output logic [2**ADDR_W-1:0] out
);

    localparam int unsigned OutW = 2**ADDR_W;

    logic [MaxOutW-1:0] full;

    always_comb full = onehot(MaxAddrW'(in));

    assign out = e ? full[OutW-1:0] : '0;

    if (OutW < MaxOutW) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^full[MaxOutW-1:OutW];
    end

endmodule

// File: rtl/wr_en_decoder.sv
// Registered write-enable decoder with hardwired zero register and built-in clear sweep.
module wr_en_decoder
    import wr_en_decoder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_EN  = 1'b1,
    parameter int unsigned ZERO_IDX = 2**ADDR_W-1
) (
    input logic             clk,
    input logic             reset_n,
    wr_en_decoder_if.slave  bus
);

    localparam int unsigned     OutW     = 2**ADDR_W;
    localparam logic [ADDR_W:0] LastIdx  = (ADDR_W+1)'(OutW-1);
    localparam logic [OutW-1:0] ZeroMask = ZERO_EN ? (OutW'(1) << ZERO_IDX) : '0;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [OutW-1:0]   we_q, we_d, dec_out;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dec_en;
    logic [ADDR_W-1:0] dec_sel;

    assign bus.wr_ready = (state_q == StIdle) && !bus.clr_start;

    // cnt holds the index whose strobe is on we_out this cycle, so the strobe
    // for index 0 appears in the first SWEEP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_en  = 1'b0;
        dec_sel = bus.wr_addr;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_start) begin
                    state_d = StSweep;
                    cnt_d   = '0;
                    dec_en  = 1'b1;
                    dec_sel = '0;
                end else if (bus.wr_valid) begin
                    dec_en = 1'b1;
                end
            end
            StSweep: begin
                if (cnt_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    dec_en  = 1'b1;
                    dec_sel = cnt_d[ADDR_W-1:0];
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        we_d   = dec_out & ~ZeroMask;
    end

    dec_onehot #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .in  (dec_sel),
        .e   (dec_en),
        .out (dec_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.we_out   = we_q;
    assign bus.busy     = busy_q;
    assign bus.clr_done = done_q;

endmodule

// File: tb/tb_wr_en_decoder.sv
// Bench for wr_en_decoder: a masked (ZERO_EN=1) and unmasked (ZERO_EN=0) instance share stimulus.
module tb_wr_en_decoder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_valid;
    logic       clr_start;
    logic [4:0] wr_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    wr_en_decoder_if #(.ADDR_W(5)) bus0 ();
    wr_en_decoder_if #(.ADDR_W(5)) bus1 ();

    assign bus0.wr_valid  = wr_valid;
    assign bus0.wr_addr   = wr_addr;
    assign bus0.clr_start = clr_start;
    assign bus1.wr_valid  = wr_valid;
    assign bus1.wr_addr   = wr_addr;
    assign bus1.clr_start = clr_start;

    wr_en_decoder #(.ADDR_W(5), .ZERO_EN(1'b1), .ZERO_IDX(31)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    wr_en_decoder #(.ADDR_W(5), .ZERO_EN(1'b0), .ZERO_IDX(31)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = -1 idle, 0..31 sweep index on the bus, 32 = completion cycle.
    int          m_pos = -1;
    logic [31:0] m_raw = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pos <= -1;
            m_raw <= '0;
        end else if (m_pos == -1) begin
            if (clr_start) begin
                m_pos <= 0;
                m_raw <= 32'd1;
            end else if (wr_valid) begin
                m_raw <= 32'd1 << wr_addr;
            end else begin
                m_raw <= '0;
            end
        end else if (m_pos < 31) begin
            m_pos <= m_pos + 1;
            m_raw <= 32'd1 << (m_pos + 1);
        end else if (m_pos == 31) begin
            m_pos <= 32;
            m_raw <= '0;
        end else begin
            m_pos <= -1;
            m_raw <= '0;
        end
    end

    always @(negedge clk) begin
        check("we_out masked", bus0.we_out, m_raw & ~32'h8000_0000);
        check("we_out unmasked", bus1.we_out, m_raw);
        check("busy", {30'd0, bus1.busy, bus0.busy}, {30'd0, {2{m_pos >= 0}}});
        check("clr_done", {30'd0, bus1.clr_done, bus0.clr_done}, {30'd0, {2{m_pos == 32}}});
        check("wr_ready", {30'd0, bus1.wr_ready, bus0.wr_ready},
              {30'd0, {2{(m_pos == -1) && !clr_start}}});
        check("onehot", {31'd0, $countones(bus1.we_out) <= 1}, 32'd1);
    end

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic c);
        #1;
        wr_valid  = v;
        wr_addr   = a;
        clr_start = c;
    endtask

    initial begin
        reset_n   = 1'b0;
        wr_valid  = 1'b1;
        wr_addr   = 5'd3;
        clr_start = 1'b0;
        next_cyc();
        next_cyc();
        check("lit reset we", bus0.we_out, 32'h0);
        check("lit reset busy", {31'd0, bus0.busy}, 32'd0);
        check("lit reset ready", {31'd0, bus0.wr_ready}, 32'd1);

        #1 reset_n = 1'b1;
        next_cyc();
        check("lit first write", bus0.we_out, 32'h0000_0008);
        drive(1'b0, 5'd0, 1'b0);
        next_cyc();
        check("lit strobe ends", bus0.we_out, 32'h0);

        drive(1'b1, 5'd31, 1'b0);
        next_cyc();
        check("lit zero reg masked", bus0.we_out, 32'h0);
        check("lit zero reg off", bus1.we_out, 32'h8000_0000);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(i), 1'b0);
            next_cyc();
            check("lit back-to-back", bus0.we_out, 32'd1 << i);
        end
        drive(1'b0, 5'd0, 1'b0);
        next_cyc();
        check("lit b2b tail", bus0.we_out, 32'h0);

        drive(1'b0, 5'd0, 1'b1);
        next_cyc();
        drive(1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            check("lit sweep we", bus0.we_out, (i == 31) ? 32'h0 : (32'd1 << i));
            check("lit sweep busy", {31'd0, bus0.busy}, 32'd1);
            check("lit sweep ready", {31'd0, bus0.wr_ready}, 32'd0);
            next_cyc();
        end
        check("lit done pulse", {31'd0, bus0.clr_done}, 32'd1);
        check("lit done busy", {31'd0, bus0.busy}, 32'd1);
        next_cyc();
        check("lit after done", {29'd0, bus0.clr_done, bus0.busy, bus0.wr_ready}, 32'd1);

        drive(1'b1, 5'd5, 1'b1);
        #1 check("lit clr priority", {31'd0, bus0.wr_ready}, 32'd0);
        next_cyc();
        check("lit write rejected", bus0.we_out, 32'h1);
        drive(1'b1, 5'd5, 1'b0);
        repeat (32) next_cyc();
        check("lit held done", {31'd0, bus0.clr_done}, 32'd1);
        next_cyc();
        check("lit held idle", bus0.we_out, 32'h0);
        next_cyc();
        check("lit held write", bus0.we_out, 32'h20);
        drive(1'b0, 5'd0, 1'b0);

        drive(1'b0, 5'd0, 1'b1);
        next_cyc();
        drive(1'b0, 5'd0, 1'b0);
        repeat (10) next_cyc();
        check("lit pre-reset idx10", bus0.we_out, 32'h400);
        #1 reset_n = 1'b0;
        #1 check("lit async we", bus0.we_out, 32'h0);
        check("lit async busy", {31'd0, bus0.busy}, 32'd0);
        next_cyc();
        check("lit no done", {31'd0, bus0.clr_done}, 32'd0);
        #1 reset_n = 1'b1;
        drive(1'b0, 5'd0, 1'b1);
        next_cyc();
        check("lit restart idx0", bus0.we_out, 32'h1);
        drive(1'b0, 5'd0, 1'b0);
        repeat (34) next_cyc();

        for (int i = 0; i < 600; i++) begin
            #1;
            reset_n   = ($urandom_range(0, 149) != 0);
            clr_start = ($urandom_range(0, 29) == 0);
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 31));
            next_cyc();
        end

        #1;
        reset_n   = 1'b1;
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        next_cyc();
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
